// File: rtl/vx_scoreboard_release.sv
// Per-warp register scoreboard: reserves destinations at issue and releases them on the eop writeback.
// Same-cycle eop releases are forwarded to the issue check, and consecutive blocked cycles feed a deadlock watchdog.
module vx_scoreboard_release #(
    parameter int NUM_WARPS       = 4,
    parameter int NW_BITS         = 2,
    parameter int NUM_REGS        = 64,
    parameter int NR_BITS         = 6,
    parameter int DEADLOCK_CYCLES = 10000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ibuf_valid,
    input  logic [NW_BITS-1:0] ibuf_wid,
    input  logic               ibuf_wb,
    input  logic [NR_BITS-1:0] ibuf_rd,
    input  logic [NR_BITS-1:0] ibuf_rs1,
    input  logic [NR_BITS-1:0] ibuf_rs2,
    input  logic [NR_BITS-1:0] ibuf_rs3,
    output logic               ibuf_ready,
    input  logic               wb_valid,
    input  logic [NW_BITS-1:0] wb_wid,
    input  logic [NR_BITS-1:0] wb_rd,
    input  logic               wb_eop,
    output logic               wb_ready,
    output logic [31:0]        perf_stalls,
    output logic               deadlock,
    output logic               error
);

    localparam int                 CNT_BITS = $clog2(DEADLOCK_CYCLES + 1);
    localparam logic [CNT_BITS-1:0] DL_MAX  = CNT_BITS'(DEADLOCK_CYCLES);

    logic [NUM_REGS-1:0] inuse_rows [NUM_WARPS];
    logic                wb_ready_reg;
    logic [31:0]         perf_stalls_reg;
    logic [CNT_BITS-1:0] block_cnt_reg;
    logic [CNT_BITS-1:0] block_cnt_next;
    logic                deadlock_reg;
    logic                error_reg;

    logic                wb_release;
    logic                wb_clear;
    logic                rel_hit;
    logic [NUM_REGS-1:0] wb_onehot;
    logic [NUM_REGS-1:0] rd_onehot;
    logic [NUM_REGS-1:0] rel_mask;
    logic [NUM_REGS-1:0] eff;
    logic                hazard;
    logic                issue_fire;
    logic                reserve;
    logic                blocked;

    assign wb_release = wb_valid & wb_ready_reg & wb_eop;
    assign wb_clear   = wb_release & (wb_rd != '0);
    assign wb_onehot  = NUM_REGS'(1) << wb_rd;
    assign rd_onehot  = NUM_REGS'(1) << ibuf_rd;
    assign rel_hit    = inuse_rows[wb_wid][wb_rd];

    // Forward a same-cycle eop release so a dependent instruction issues without a bubble.
    assign rel_mask   = (wb_release && (wb_wid == ibuf_wid)) ? wb_onehot : '0;
    assign eff        = inuse_rows[ibuf_wid] & ~rel_mask;
    assign hazard     = eff[ibuf_rs1] | eff[ibuf_rs2] | eff[ibuf_rs3] | (ibuf_wb & eff[ibuf_rd]);

    assign ibuf_ready = reset & ~hazard;
    assign issue_fire = ibuf_valid & ibuf_ready;
    assign reserve    = issue_fire & ibuf_wb & (ibuf_rd != '0);
    assign blocked    = ibuf_valid & ~ibuf_ready;

    generate
        for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            logic [NUM_REGS-1:0] row_reg;
            logic [NUM_REGS-1:0] set_mask;
            logic [NUM_REGS-1:0] clr_mask;

            assign set_mask = (reserve  && (ibuf_wid == NW_BITS'(gi))) ? rd_onehot : '0;
            assign clr_mask = (wb_clear && (wb_wid   == NW_BITS'(gi))) ? wb_onehot : '0;

            // Set is applied after clear so a simultaneous reserve keeps the bit.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    row_reg <= '0;
                end else begin
                    row_reg <= (row_reg & ~clr_mask) | set_mask;
                end
            end

            assign inuse_rows[gi] = row_reg;
        end
    endgenerate

    always_comb begin
        block_cnt_next = '0;
        if (blocked) begin
            block_cnt_next = (block_cnt_reg == DL_MAX) ? DL_MAX : block_cnt_reg + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_ready_reg    <= 1'b0;
            perf_stalls_reg <= '0;
            block_cnt_reg   <= '0;
            deadlock_reg    <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            wb_ready_reg    <= 1'b1;
            perf_stalls_reg <= perf_stalls_reg + {31'd0, blocked};
            block_cnt_reg   <= block_cnt_next;
            deadlock_reg    <= (block_cnt_next == DL_MAX);
            error_reg       <= error_reg | (wb_clear & ~rel_hit);
        end
    end

    assign wb_ready    = wb_ready_reg;
    assign perf_stalls = perf_stalls_reg;
    assign deadlock    = deadlock_reg;
    assign error       = error_reg;

endmodule
